// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle control sequencer.
//   - state_t  : FSM state codes. The encoding is visible on the debug port.
//   - OP_*     : opcode field values (IR[31:26]).
//   - FN_*     : R-type func field values (IR[5:0]).
//   - ALU_*    : ALU operation codes driven on aluop.
//   - PC_SRC_* : PC mux select encodings.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: combinational instruction decode for the ALU path.
// Ports:
//   opcode [5:0] in  : IR[31:26]
//   func   [5:0] in  : IR[5:0]
//   aluop  [3:0] out : ALU operation for this instruction
//   alusrc       out : 1 = extended immediate, 0 = rd2
//   extop        out : 1 = sign extend, 0 = zero extend
//   regdst       out : 1 = rd, 0 = rt
//   legal        out : instruction is supported
// Outputs are not gated here; the sequencer qualifies them by state.
module mc_alu_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output logic [3:0] aluop,
    output logic       alusrc,
    output logic       extop,
    output logic       regdst,
    output logic       legal
);

    always_comb begin
        aluop  = ALU_AND;
        alusrc = 1'b0;
        extop  = 1'b0;
        regdst = 1'b0;
        legal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                regdst = 1'b1;
                legal  = 1'b1;
                case (func)
                    FN_ADD:  aluop = ALU_ADD;
                    FN_SUB:  aluop = ALU_SUB;
                    FN_AND:  aluop = ALU_AND;
                    FN_OR:   aluop = ALU_OR;
                    FN_SLT:  aluop = ALU_SLT;
                    default: legal = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI: begin
                alusrc = 1'b1;
                extop  = 1'b1;
                aluop  = ALU_ADD;
                legal  = 1'b1;
            end
            OP_ANDI: begin
                alusrc = 1'b1;
                aluop  = ALU_AND;
                legal  = 1'b1;
            end
            OP_ORI: begin
                alusrc = 1'b1;
                aluop  = ALU_OR;
                legal  = 1'b1;
            end
            OP_BEQ: begin
                aluop = ALU_SUB;
                legal = 1'b1;
            end
            OP_J: begin
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control FSM for the MIPS-style datapath.
// Optional build macro: MC_PERF_CNT_EN adds the retired/cycles counters.
// Parameter RESET_RUN: 1 = leave IDLE on the first clock after reset.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   run                         : 1 = keep fetching instructions
//   opcode, func, zero          : IR fields and ALU zero flag
//   imem_ready, dmem_ready      : memory handshakes (wait states)
//   pc_write, pc_src, ir_write  : fetch / PC control
//   regdst, alusrc, extop, aluop: datapath steering
//   memread, memwrite, mem2reg  : data memory control
//   regwrite                    : register bank write strobe
//   illegal                     : sticky, undecodable instruction seen
//   state                       : current state code (debug)
//   retired, cycles             : performance counters (MC_PERF_CNT_EN only)
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | load IR and PC+4 when imem_ready
// DECODE | check opcode/func, no strobes
// EXEC   | ALU operation; beq/j resolve the PC here and end
// MEM    | lw read / sw write until dmem_ready
// WB     | one-cycle register write
// TRAP   | illegal instruction, held until reset
module mc_sequencer
    import mc_pkg::*;
#(
    parameter bit RESET_RUN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        regdst,
    output logic        alusrc,
    output logic        extop,
    output logic [3:0]  aluop,
    output logic        memread,
    output logic        memwrite,
    output logic        mem2reg,
    output logic        regwrite,
    output logic        illegal,
    output logic [2:0]  state
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] retired,
    output logic [31:0] cycles
`endif
);

    state_t     state_q, state_d;
    logic       first_q;
    logic       illegal_q;
    logic       inst_end;
    logic [3:0] dec_aluop;
    logic       dec_alusrc, dec_extop, dec_regdst, dec_legal;
    logic       is_lw, is_sw, is_beq, is_j;

    mc_alu_decode u_alu_decode (
        .opcode (opcode),
        .func   (func),
        .aluop  (dec_aluop),
        .alusrc (dec_alusrc),
        .extop  (dec_extop),
        .regdst (dec_regdst),
        .legal  (dec_legal)
    );

    assign is_lw  = (opcode == OP_LW);
    assign is_sw  = (opcode == OP_SW);
    assign is_beq = (opcode == OP_BEQ);
    assign is_j   = (opcode == OP_J);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            first_q   <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= 1'b0;
            if (state_d == S_TRAP) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        inst_end = 1'b0;
        pc_write = 1'b0;
        pc_src   = PC_SRC_SEQ;
        ir_write = 1'b0;
        regdst   = 1'b0;
        alusrc   = 1'b0;
        extop    = 1'b0;
        aluop    = ALU_AND;
        memread  = 1'b0;
        memwrite = 1'b0;
        mem2reg  = 1'b0;
        regwrite = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run || (RESET_RUN && first_q)) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = dec_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                alusrc = dec_alusrc;
                extop  = dec_extop;
                aluop  = dec_aluop;
                regdst = dec_regdst;
                if (is_beq) begin
                    pc_src   = PC_SRC_BRANCH;
                    pc_write = zero;
                    inst_end = 1'b1;
                end else if (is_j) begin
                    pc_src   = PC_SRC_JUMP;
                    pc_write = 1'b1;
                    inst_end = 1'b1;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // ALU controls stay applied so the address remains stable
                // across data memory wait states.
                alusrc = dec_alusrc;
                extop  = dec_extop;
                aluop  = dec_aluop;
                if (is_lw) begin
                    memread = 1'b1;
                    if (dmem_ready) state_d = S_WB;
                end else begin
                    memwrite = 1'b1;
                    if (dmem_ready) inst_end = 1'b1;
                end
            end
            S_WB: begin
                // ALU result is the write-back data for non-load instructions.
                alusrc   = dec_alusrc;
                extop    = dec_extop;
                aluop    = dec_aluop;
                regdst   = dec_regdst;
                mem2reg  = is_lw;
                regwrite = 1'b1;
                inst_end = 1'b1;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: state_d = S_IDLE;
        endcase
        if (inst_end) state_d = run ? S_FETCH : S_IDLE;
    end

    assign illegal = illegal_q;
    assign state   = state_q;

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= 32'd0;
            cycles  <= 32'd0;
        end else begin
            if (inst_end) retired <= retired + 32'd1;
            if (state_q != S_IDLE && state_q != S_TRAP) cycles <= cycles + 32'd1;
        end
    end
`endif

endmodule
